// File: rtl/cpu_memory_if.sv
// rtl/cpu_memory_if.sv - 16-bit Wishbone-style data bus between the memory stage and data memory
interface cpu_memory_if;
  logic [31:0] address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  sel;
  logic        stb;
  logic        cyc;
  logic        we;
  logic        ack;

  modport master (output address, wdata, sel, stb, cyc, we, input rdata, ack);
  modport slave  (input address, wdata, sel, stb, cyc, we, output rdata, ack);
endinterface

// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - memory pipeline stage: loads/stores over a 16-bit bus, big-endian beats for words
module cpu_memory #(
  parameter int PCB_WIDTH = 6,
  parameter int PCB_WA    = 0,
  parameter int PCB_WB    = 1,
  parameter int PCB_RM    = 2,
  parameter int PCB_WM    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [1:0]           mem_size_i,
  output logic                 stall_o,
  cpu_memory_if.master         dmem,
  output logic [PCB_WIDTH-1:0] pipeline_control_bits_o,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic [31:0]          reg0_result_o,
  output logic [31:0]          reg1_result_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
  state_t state_q, state_d;

  logic [PCB_WIDTH-1:0] pcb_q;
  logic [3:0]           idx0_q, idx1_q;
  logic [31:0]          r0_q, r1_q;
  logic                 addr_lsb_q;
  logic [15:0]          data_lo_q;
  logic [1:0]           size_q;
  logic [15:0]          hi_q;

  logic is_mem, accept, final_ack;
  logic [31:0] addr0;
  logic [1:0]  sel0;
  logic [15:0] wdata0;
  logic [31:0] load_val;

  logic [PCB_WIDTH-1:0] pcb_d;
  logic        wea_d, web_d, stb_d, cyc_d, we_d;
  logic [3:0]  idx0_d, idx1_d;
  logic [31:0] reg0_d, reg1_d, addr_d;
  logic [15:0] wdata_d;
  logic [1:0]  sel_d;

  assign is_mem    = pipeline_control_bits_i[PCB_RM] | pipeline_control_bits_i[PCB_WM];
  assign accept    = (state_q == IDLE) && is_mem && !flush_i;
  assign final_ack = dmem.ack && ((state_q == BEAT0 && !size_q[1]) || state_q == BEAT1);
  // Stall drops in the completion cycle so upstream advances on the same edge we write back.
  assign stall_o   = accept || ((state_q != IDLE) && !final_ack);

  always_comb begin
    addr0 = (mem_size_i == 2'b00) ? memory_address_i : {memory_address_i[31:1], 1'b0};
    sel0  = 2'b11;
    if (mem_size_i == 2'b00) sel0 = memory_address_i[0] ? 2'b01 : 2'b10;
    case (mem_size_i)
      2'b00:   wdata0 = {2{mem_result_i[7:0]}};
      2'b01:   wdata0 = mem_result_i[15:0];
      default: wdata0 = mem_result_i[31:16];
    endcase
    case (size_q)
      2'b00:   load_val = {24'd0, addr_lsb_q ? dmem.rdata[7:0] : dmem.rdata[15:8]};
      2'b01:   load_val = {16'd0, dmem.rdata};
      default: load_val = {hi_q, dmem.rdata};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q                 <= IDLE;
      pipeline_control_bits_o <= '0;
      register_wea_o          <= 1'b0;
      register_web_o          <= 1'b0;
      register0_write_index_o <= '0;
      register1_write_index_o <= '0;
      reg0_result_o           <= '0;
      reg1_result_o           <= '0;
      dmem.address            <= '0;
      dmem.wdata              <= '0;
      dmem.sel                <= '0;
      dmem.stb                <= 1'b0;
      dmem.cyc                <= 1'b0;
      dmem.we                 <= 1'b0;
    end else begin
      state_q                 <= state_d;
      pipeline_control_bits_o <= pcb_d;
      register_wea_o          <= wea_d;
      register_web_o          <= web_d;
      register0_write_index_o <= idx0_d;
      register1_write_index_o <= idx1_d;
      reg0_result_o           <= reg0_d;
      reg1_result_o           <= reg1_d;
      dmem.address            <= addr_d;
      dmem.wdata              <= wdata_d;
      dmem.sel                <= sel_d;
      dmem.stb                <= stb_d;
      dmem.cyc                <= cyc_d;
      dmem.we                 <= we_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcb_q      <= '0;
      idx0_q     <= '0;
      idx1_q     <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      addr_lsb_q <= 1'b0;
      data_lo_q  <= '0;
      size_q     <= '0;
      hi_q       <= '0;
    end else begin
      if (accept) begin
        pcb_q      <= pipeline_control_bits_i;
        idx0_q     <= register0_write_index_i;
        idx1_q     <= register1_write_index_i;
        r0_q       <= reg0_result_i;
        r1_q       <= reg1_result_i;
        addr_lsb_q <= memory_address_i[0];
        data_lo_q  <= mem_result_i[15:0];
        size_q     <= mem_size_i;
      end
      if (state_q == BEAT0 && dmem.ack) hi_q <= dmem.rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0:   if (dmem.ack) state_d = size_q[1] ? BEAT1 : IDLE;
      BEAT1:   if (dmem.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pcb_d   = '0;
    wea_d   = 1'b0;
    web_d   = 1'b0;
    idx0_d  = register0_write_index_o;
    idx1_d  = register1_write_index_o;
    reg0_d  = reg0_result_o;
    reg1_d  = reg1_result_o;
    addr_d  = dmem.address;
    wdata_d = dmem.wdata;
    sel_d   = dmem.sel;
    stb_d   = dmem.stb;
    cyc_d   = dmem.cyc;
    we_d    = dmem.we;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = addr0;
          wdata_d = wdata0;
          sel_d   = sel0;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          we_d    = pipeline_control_bits_i[PCB_WM];
        end else begin
          pcb_d  = flush_i ? '0 : pipeline_control_bits_i;
          wea_d  = !flush_i && pipeline_control_bits_i[PCB_WA];
          web_d  = !flush_i && pipeline_control_bits_i[PCB_WB];
          idx0_d = register0_write_index_i;
          idx1_d = register1_write_index_i;
          reg0_d = reg0_result_i;
          reg1_d = reg1_result_i;
        end
      end
      default: begin
        if (final_ack) begin
          stb_d  = 1'b0;
          cyc_d  = 1'b0;
          we_d   = 1'b0;
          pcb_d  = pcb_q;
          wea_d  = pcb_q[PCB_WA];
          web_d  = pcb_q[PCB_WB];
          idx0_d = idx0_q;
          idx1_d = idx1_q;
          reg0_d = pcb_q[PCB_WM] ? r0_q : load_val;
          reg1_d = r1_q;
        end else if (state_q == BEAT0 && dmem.ack) begin
          // Second beat of a word: low half at the next halfword, strobe kept asserted.
          addr_d  = dmem.address + 32'd2;
          wdata_d = data_lo_q;
        end
      end
    endcase
  end

endmodule
